// File: rtl/syncdet.sv
// Frame-sync decision stage: qualifies runs of comparator hits as sync,
// reports where the run began, then tracks lock until too many misses.
module syncdet #(
   parameter int IDXW       = 16,
   parameter int HITS       = 4,
   parameter int MISSES     = 8,
   parameter int SEARCH_LEN = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            synctop_syncdet_start,
   input  logic            thcomp_thcomptop_finish,
   input  logic            thcomp_thcomptop_data,
   output logic            syncdet_synctop_found,
   output logic            syncdet_synctop_timeout,
   output logic            syncdet_synctop_lost,
   output logic            syncdet_synctop_locked,
   output logic            syncdet_synctop_busy,
   output logic [IDXW-1:0] syncdet_synctop_index
);

   typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SEARCH_LEN - 1);
   localparam logic [3:0]      HITS_C   = 4'(HITS);
   localparam logic [7:0]      MISSES_C = 8'(MISSES);

   state_t          state_q;
   logic [IDXW-1:0] idx_q;
   logic [IDXW-1:0] run_start_q;
   logic [IDXW-1:0] index_q;
   logic [3:0]      hit_cnt_q;
   logic [7:0]      miss_cnt_q;
   logic            found_q;
   logic            timeout_q;
   logic            lost_q;
   logic            locked_q;
   logic            busy_q;

   logic [3:0]      hit_cnt_d;
   logic [7:0]      miss_cnt_d;

   always_comb begin
      hit_cnt_d  = thcomp_thcomptop_data ? hit_cnt_q + 4'd1 : '0;
      miss_cnt_d = thcomp_thcomptop_data ? '0 : miss_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         run_start_q <= '0;
         index_q     <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         found_q     <= 1'b0;
         timeout_q   <= 1'b0;
         lost_q      <= 1'b0;
         locked_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         found_q   <= 1'b0;
         timeout_q <= 1'b0;
         lost_q    <= 1'b0;
         // start has priority over any result in the same cycle, in every state
         if (synctop_syncdet_start) begin
            state_q     <= SEARCH;
            idx_q       <= '0;
            run_start_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            busy_q      <= 1'b1;
            locked_q    <= 1'b0;
         end else if (thcomp_thcomptop_finish) begin
            case (state_q)
               SEARCH: begin
                  if (thcomp_thcomptop_data && hit_cnt_q == '0)
                     run_start_q <= idx_q;
                  hit_cnt_q <= hit_cnt_d;
                  if (idx_q != LAST_IDX)
                     idx_q <= idx_q + 1'b1;
                  // a run starting on this very result has no stored run_start yet
                  if (thcomp_thcomptop_data && hit_cnt_d == HITS_C) begin
                     found_q    <= 1'b1;
                     index_q    <= (hit_cnt_q == '0) ? idx_q : run_start_q;
                     state_q    <= LOCKED;
                     miss_cnt_q <= '0;
                     locked_q   <= 1'b1;
                     busy_q     <= 1'b0;
                  end else if (idx_q == LAST_IDX) begin
                     timeout_q <= 1'b1;
                     state_q   <= IDLE;
                     busy_q    <= 1'b0;
                  end
               end
               LOCKED: begin
                  miss_cnt_q <= miss_cnt_d;
                  if (miss_cnt_d == MISSES_C) begin
                     lost_q   <= 1'b1;
                     locked_q <= 1'b0;
                     state_q  <= IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign syncdet_synctop_found   = found_q;
   assign syncdet_synctop_timeout = timeout_q;
   assign syncdet_synctop_lost    = lost_q;
   assign syncdet_synctop_locked  = locked_q;
   assign syncdet_synctop_busy    = busy_q;
   assign syncdet_synctop_index   = index_q;

endmodule
